// File: rtl/reaction_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer_ctrl_pkg
// Brief    : State encoding and BCD constants for the reaction timer.
// Revision : 1.0
// ============================================================================
package reaction_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_GO     = 3'd2,
    ST_RESULT = 3'd3,
    ST_FOUL   = 3'd4
  } state_t;

  localparam int          BCD_DIGITS = 4;
  localparam logic [15:0] BCD_MAX    = 16'h9999;
  localparam logic [3:0]  DIGIT_MAX  = 4'd9;

  // The generator can emit 10..15; treat those as the longest delay.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_timer_ctrl_bcd_counter4.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter4
// Brief    : Four-digit BCD incrementer that saturates at 9999.
// Revision : 1.0
// ============================================================================
module bcd_counter4
  import reaction_timer_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    inc,
  output logic [4*BCD_DIGITS-1:0] value,
  output logic                    at_max
);

  logic [BCD_DIGITS-1:0] w_carry;

  assign at_max     = (value == BCD_MAX);
  assign w_carry[0] = inc & ~at_max;

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
    logic [3:0] r_dig;

    always_ff @(posedge clk) begin
      if (reset || clr) begin
        r_dig <= 4'd0;
      end else if (w_carry[gi]) begin
        r_dig <= (r_dig == 4'd9) ? 4'd0 : r_dig + 4'd1;
      end
    end

    assign value[4*gi +: 4] = r_dig;

    if (gi < BCD_DIGITS - 1) begin : g_chain
      assign w_carry[gi+1] = w_carry[gi] & (r_dig == 4'd9);
    end
  end

endmodule
`default_nettype wire

// File: rtl/reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer_ctrl
// Brief    : Reaction-time trial controller with random delay and BCD result.
// Revision : 1.0
// ============================================================================
module reaction_timer_ctrl
  import reaction_timer_ctrl_pkg::*;
#(
  parameter int DELAY_TICKS = 50000000,
  parameter int MS_TICKS    = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        press,
  input  logic [3:0]  rand_digit,
  output logic        rand_stop,
  output logic        led,
  output logic        busy,
  output logic        done,
  output logic        foul,
  output logic [15:0] time_bcd
);

  localparam int c_delay_w = $clog2(10*DELAY_TICKS + 1);
  localparam int c_presc_w = $clog2(MS_TICKS + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_digit;
  logic [c_delay_w-1:0] r_delay;
  logic [c_delay_w-1:0] w_delay_last;
  logic [c_presc_w-1:0] r_presc;
  logic                 w_start_trial;
  logic                 w_delay_done;
  logic                 w_tick_ms;
  logic                 w_bcd_inc;
  logic                 w_at_max;
  logic [15:0]          w_bcd;

  assign w_delay_last  = c_delay_w'((32'(r_digit) + 32'd1) * 32'(DELAY_TICKS) - 32'd1);
  assign w_delay_done  = (r_delay == w_delay_last);
  assign w_tick_ms     = (r_presc == c_presc_w'(MS_TICKS - 1));
  assign w_start_trial = start &&
                         (r_state == ST_IDLE || r_state == ST_RESULT || r_state == ST_FOUL);
  // A press freezes the display on the value it showed in the press cycle.
  assign w_bcd_inc     = (r_state == ST_GO) && w_tick_ms && !press;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_RESULT, ST_FOUL: begin
        if (start) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (press)             w_state_next = ST_FOUL;
        else if (w_delay_done) w_state_next = ST_GO;
      end
      ST_GO: begin
        if (press || w_at_max) w_state_next = ST_RESULT;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit <= 4'd0;
      r_delay <= '0;
      r_presc <= '0;
    end else if (w_start_trial) begin
      r_digit <= clamp_digit(rand_digit);
      r_delay <= '0;
      r_presc <= '0;
    end else begin
      if (r_state == ST_WAIT) r_delay <= r_delay + c_delay_w'(1);
      if (r_state == ST_GO)   r_presc <= w_tick_ms ? '0 : r_presc + c_presc_w'(1);
    end
  end

  bcd_counter4 u_time (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_start_trial),
    .inc    (w_bcd_inc),
    .value  (w_bcd),
    .at_max (w_at_max)
  );

  assign busy      = (r_state == ST_WAIT) || (r_state == ST_GO);
  assign rand_stop = busy;
  assign led       = (r_state == ST_GO);
  assign done      = (r_state == ST_RESULT);
  assign foul      = (r_state == ST_FOUL);
  assign time_bcd  = w_bcd;

endmodule
`default_nettype wire

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
- Consumes the 0–9 random digit from the upstream LFSR digit generator.
- Drives that generator's stop input, freezing it while a trial is running.
- Runs a reaction-time trial:
  - waits a random delay derived from the latched digit;
  - lights the go LED;
  - measures time to button press in BCD milliseconds for the seven-segment display stage.
- A press before the LED lights is flagged as a foul.

Parameters:
- DELAY_TICKS, 50000000, clock cycles per delay unit; total random delay is (digit+1) units.
- MS_TICKS, 100000, clock cycles per counted millisecond.
- Benches override both parameters with small values.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  debounced single-cycle pulse; begins a trial.
- press  input  1  debounced single-cycle reaction-button pulse.
- rand_digit  input  4  digit from the upstream generator, nominally 0–9.
- rand_stop  output  1  to generator stop input; 1 freezes the generator.
- led  output  1  go indicator.
- busy  output  1  trial in progress (WAIT or GO).
- done  output  1  valid result held on time_bcd.
- foul  output  1  early press detected.
- time_bcd  output  16  four BCD digits of milliseconds; [15:12] is thousands.

Behaviour:
- Reset:
  - synchronous, active-high, highest priority;
  - applies mid-trial as well;
  - next edge gives state IDLE and all outputs 0, time_bcd 16'h0000, internal counters 0.
- All outputs are registered and decoded from state and registers. No combinational path from inputs to outputs.
- States: IDLE, WAIT, GO, RESULT, FOUL.
- IDLE:
  - rand_stop=0, so the generator runs freely;
  - start=1 goes to WAIT on the next edge.
  - At that same edge: the digit is latched (rand_digit values 10–15 clamp to 9), the delay counter clears, time_bcd clears to 0000, and done and foul clear.
- WAIT:
  - busy=1, rand_stop=1, led=0;
  - the delay counter increments every cycle;
  - after exactly (digit+1)*DELAY_TICKS cycles in WAIT, go to GO;
  - press=1 in WAIT goes to FOUL on the next edge (press beats delay expiry on the same cycle);
  - start is ignored.
- GO:
  - led=1, busy=1, rand_stop=1;
  - a millisecond prescaler counts cycles; every MS_TICKS cycles time_bcd increments in BCD, with each digit wrapping 9→0 and carrying;
  - time_bcd saturates at 9999;
  - press=1 goes to RESULT. time_bcd freezes at its value in the press cycle; an increment due in that same cycle is suppressed;
  - if time_bcd reaches 9999 with no press, go to RESULT (timeout);
  - start is ignored.
- RESULT:
  - done=1, led=0, busy=0, rand_stop=0;
  - time_bcd is held;
  - press is ignored;
  - start=1 begins a new trial exactly as from IDLE.
- FOUL:
  - foul=1, time_bcd=0000, rand_stop=0;
  - start=1 begins a new trial exactly as from IDLE.
- Simultaneous start and press:
  - in IDLE, RESULT or FOUL: start wins and press is ignored;
  - in WAIT: press wins (start is ignored in WAIT).
- Latency:
  - start at cycle n gives busy=1 at n+1;
  - led=1 at n+1+(d+1)*DELAY_TICKS;
  - press at cycle m gives done=1 at m+1.
- Counter widths:
  - delay counter sized for 10*DELAY_TICKS;
  - prescaler sized for MS_TICKS.

Decomposition:
- Shared package:
  - state encoding (3-bit enum of the five states);
  - BCD_DIGITS=4;
  - BCD_MAX=16'h9999;
  - DIGIT_MAX=9.
- One sub-module: bcd_counter4.
  - Function: 4-digit saturating BCD incrementer.
  - Inputs: clk, reset, clr, inc.
  - Outputs: value[15:0], at_max.
  - Instantiated once for time_bcd.

Test Plan (DELAY_TICKS=4, MS_TICKS=2 unless stated):
- Reset mid-GO, then reset released → next edge gives IDLE, led=0, busy=0, time_bcd=0000, rand_stop=0.
- rand_digit=2, start → busy next cycle; led rises exactly 12 cycles after entering WAIT; press 7 cycles after led → done=1, time_bcd=0003.
- rand_digit=5, press 3 cycles after start → foul=1, led never asserts, time_bcd=0000, rand_stop=0.
- rand_digit=12, start → digit clamped; led after 40 WAIT cycles.
- MS_TICKS=1, no press in GO → time_bcd passes 0009→0010 and 0099→0100, stops at 9999; done=1, led=0.
- From RESULT, start and press in the same cycle → new trial starts, done and foul cleared, time_bcd=0000; press ignored.
